core_management_arbiter: RTL and testbench

- Registered round-robin arbiter and transaction sequencer between the JTAG and Wishbone management masters and the single core management bus.
- Replaces the combinational fixed-priority JTAG-over-WB select in front of the core management registers and core memory window.
- Latches one request at a time and drives it onto the bus until the target stops stalling. Returns a one-cycle ack with registered read data to the winning master.

---
 rtl/core_management_arbiter.sv | 175 +++++++++++++++++
 tb/tb_core_management_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_management_arbiter.sv
// Registered round-robin arbiter/sequencer between JTAG and Wishbone masters and the core management bus.
// Optional stall timeout enabled by defining CORE_MANAGEMENT_TIMEOUT_EN.
module core_management_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jtag_req,
  input  logic        jtag_we,
  input  logic [3:0]  jtag_byteSelect,
  input  logic [19:0] jtag_address,
  input  logic [31:0] jtag_writeData,
  output logic        jtag_ack,
  output logic [31:0] jtag_readData,
  output logic        jtag_error,
  input  logic        wb_req,
  input  logic        wb_we,
  input  logic [3:0]  wb_byteSelect,
  input  logic [19:0] wb_address,
  input  logic [31:0] wb_writeData,
  output logic        wb_ack,
  output logic [31:0] wb_readData,
  output logic        wb_error,
  output logic        mgmt_writeEnable,
  output logic        mgmt_readEnable,
  output logic [3:0]  mgmt_byteSelect,
  output logic [19:0] mgmt_address,
  output logic [31:0] mgmt_writeData,
  input  logic [31:0] mgmt_readData,
  input  logic        mgmt_busy,
  output logic        lastGrant
);

  // state  | meaning
  // IDLE   | waiting for a request, arbitrates on entry
  // ACCESS | latched transaction driven onto the bus until not busy
  // DONE   | one-cycle ack to the grantee, lastGrant updated
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        grant_q, grant_d;   // 1 = Wishbone
  logic        last_q, last_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [19:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] jrd_q, jrd_d;
  logic [31:0] wrd_q, wrd_d;
  logic        win;

`ifdef CORE_MANAGEMENT_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
  logic        to_q, to_d;
`endif

  // Wishbone wins when alone, or on a tie when JTAG owned the last transaction.
  assign win = wb_req && (!jtag_req || !last_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    jrd_d   = jrd_q;
    wrd_d   = wrd_q;
`ifdef CORE_MANAGEMENT_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = to_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (jtag_req || wb_req) begin
          grant_d = win;
          we_d    = win ? wb_we           : jtag_we;
          be_d    = win ? wb_byteSelect   : jtag_byteSelect;
          addr_d  = win ? wb_address      : jtag_address;
          wdata_d = win ? wb_writeData    : jtag_writeData;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!mgmt_busy) begin
          if (!we_q) begin
            if (grant_q) wrd_d = mgmt_readData;
            else         jrd_d = mgmt_readData;
          end
          state_d = ST_DONE;
        end
`ifdef CORE_MANAGEMENT_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          if (grant_q) wrd_d = 32'hFFFF_FFFF;
          else         jrd_d = 32'hFFFF_FFFF;
          to_d    = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      ST_DONE: begin
        last_d  = grant_q;
        state_d = ST_IDLE;
`ifdef CORE_MANAGEMENT_TIMEOUT_EN
        cnt_d   = '0;
        to_d    = 1'b0;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      jrd_q   <= '0;
      wrd_q   <= '0;
`ifdef CORE_MANAGEMENT_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      jrd_q   <= jrd_d;
      wrd_q   <= wrd_d;
`ifdef CORE_MANAGEMENT_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  logic in_access, in_done;
  assign in_access = (state_q == ST_ACCESS);
  assign in_done   = (state_q == ST_DONE);

  // Bus outputs depend only on registers, so reset drops them at once.
  assign mgmt_writeEnable = in_access &  we_q;
  assign mgmt_readEnable  = in_access & ~we_q;
  assign mgmt_byteSelect  = in_access ? be_q    : '0;
  assign mgmt_address     = in_access ? addr_q  : '0;
  assign mgmt_writeData   = in_access ? wdata_q : '0;

  assign jtag_ack      = in_done & ~grant_q;
  assign wb_ack        = in_done &  grant_q;
  assign jtag_readData = jrd_q;
  assign wb_readData   = wrd_q;
  assign lastGrant     = last_q;

`ifdef CORE_MANAGEMENT_TIMEOUT_EN
  assign jtag_error = in_done & to_q & ~grant_q;
  assign wb_error   = in_done & to_q &  grant_q;
`else
  assign jtag_error = 1'b0;
  assign wb_error   = 1'b0;
`endif

endmodule

// File: tb/tb_core_management_arbiter.sv
// Randomized self-checking bench for core_management_arbiter against a transaction-level model.
module tb_core_management_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jtag_req = 0, jtag_we = 0;
  logic [3:0]  jtag_byteSelect = 0;
  logic [19:0] jtag_address = 0;
  logic [31:0] jtag_writeData = 0;
  logic        jtag_ack, jtag_error;
  logic [31:0] jtag_readData;
  logic        wb_req = 0, wb_we = 0;
  logic [3:0]  wb_byteSelect = 0;
  logic [19:0] wb_address = 0;
  logic [31:0] wb_writeData = 0;
  logic        wb_ack, wb_error;
  logic [31:0] wb_readData;
  logic        mgmt_writeEnable, mgmt_readEnable;
  logic [3:0]  mgmt_byteSelect;
  logic [19:0] mgmt_address;
  logic [31:0] mgmt_writeData;
  logic [31:0] mgmt_readData = 0;
  logic        mgmt_busy = 0;
  logic        lastGrant;

  core_management_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .jtag_req(jtag_req), .jtag_we(jtag_we), .jtag_byteSelect(jtag_byteSelect),
    .jtag_address(jtag_address), .jtag_writeData(jtag_writeData),
    .jtag_ack(jtag_ack), .jtag_readData(jtag_readData), .jtag_error(jtag_error),
    .wb_req(wb_req), .wb_we(wb_we), .wb_byteSelect(wb_byteSelect),
    .wb_address(wb_address), .wb_writeData(wb_writeData),
    .wb_ack(wb_ack), .wb_readData(wb_readData), .wb_error(wb_error),
    .mgmt_writeEnable(mgmt_writeEnable), .mgmt_readEnable(mgmt_readEnable),
    .mgmt_byteSelect(mgmt_byteSelect), .mgmt_address(mgmt_address),
    .mgmt_writeData(mgmt_writeData), .mgmt_readData(mgmt_readData),
    .mgmt_busy(mgmt_busy), .lastGrant(lastGrant)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // model state
  bit          m_last = 1'b1;
  logic [31:0] m_jrd = '0, m_wrd = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rand_fields();
    jtag_we = 1'($urandom); jtag_byteSelect = 4'($urandom);
    jtag_address = 20'($urandom); jtag_writeData = $urandom;
    wb_we = 1'($urandom); wb_byteSelect = 4'($urandom);
    wb_address = 20'($urandom); wb_writeData = $urandom;
  endtask

  // Starts at a negedge in IDLE, ends at a negedge in IDLE.
  task automatic do_txn(input bit jr, input bit wr, input int stalls, input bit scramble);
    bit          w, busy_now, timed_out;
    logic        e_we;
    logic [3:0]  e_be;
    logic [19:0] e_addr;
    logic [31:0] e_wd, rdv;
    w      = (jr && wr) ? !m_last : wr;
    e_we   = w ? wb_we : jtag_we;
    e_be   = w ? wb_byteSelect : jtag_byteSelect;
    e_addr = w ? wb_address : jtag_address;
    e_wd   = w ? wb_writeData : jtag_writeData;
    timed_out = 0;
    jtag_req = jr; wb_req = wr; mgmt_busy = 0;
    @(posedge clk);
    for (int k = 0; k <= stalls; k++) begin
      @(negedge clk);
      chk("acc_we", {31'b0, mgmt_writeEnable}, {31'b0, e_we});
      chk("acc_re", {31'b0, mgmt_readEnable}, {31'b0, !e_we});
      chk("acc_addr", {12'b0, mgmt_address}, {12'b0, e_addr});
      chk("acc_be", {28'b0, mgmt_byteSelect}, {28'b0, e_be});
      chk("acc_wd", mgmt_writeData, e_wd);
      chk("acc_acks", {30'b0, jtag_ack, wb_ack}, 32'd0);
      busy_now = (k < stalls);
`ifdef CORE_MANAGEMENT_TIMEOUT_EN
      timed_out = busy_now && (k + 1 == TO);
`endif
      rdv = $urandom;
      mgmt_busy = busy_now;
      mgmt_readData = rdv;
      if (timed_out) begin
        if (w) m_wrd = 32'hFFFF_FFFF; else m_jrd = 32'hFFFF_FFFF;
      end else if (!busy_now && !e_we) begin
        if (w) m_wrd = rdv; else m_jrd = rdv;
      end
      if (scramble && k == 0) begin
        rand_fields();
        if (w) wb_req = 0; else jtag_req = 0;
      end
      @(posedge clk);
      if (!busy_now || timed_out) break;
    end
    @(negedge clk);
    chk("done_jack", {31'b0, jtag_ack}, {31'b0, !w});
    chk("done_wack", {31'b0, wb_ack}, {31'b0, w});
    chk("done_jerr", {31'b0, jtag_error}, {31'b0, timed_out && !w});
    chk("done_werr", {31'b0, wb_error}, {31'b0, timed_out && w});
    chk("done_strb", {30'b0, mgmt_writeEnable, mgmt_readEnable}, 32'd0);
    chk("done_addr", {12'b0, mgmt_address}, 32'd0);
    chk("jrd", jtag_readData, m_jrd);
    chk("wrd", wb_readData, m_wrd);
    jtag_req = 0; wb_req = 0; mgmt_busy = 0;
    @(posedge clk);
    @(negedge clk);
    m_last = w;
    chk("last_grant", {31'b0, lastGrant}, {31'b0, m_last});
    chk("idle_acks", {30'b0, jtag_ack, wb_ack}, 32'd0);
    chk("idle_strb", {30'b0, mgmt_writeEnable, mgmt_readEnable}, 32'd0);
  endtask

  initial begin
    bit jr, wr;
    #17;
    chk("rst_last", {31'b0, lastGrant}, 32'd1);
    chk("rst_acks", {30'b0, jtag_ack, wb_ack}, 32'd0);
    chk("rst_strb", {30'b0, mgmt_writeEnable, mgmt_readEnable}, 32'd0);
    chk("rst_rd", jtag_readData | wb_readData, 32'd0);
    @(negedge clk); rst = 1;
    @(negedge clk);

    // JTAG read of 0x00004 returning 0x13
    jtag_we = 0; jtag_address = 20'h00004; jtag_byteSelect = 4'hF; jtag_writeData = 0;
    jtag_req = 1; mgmt_busy = 0;
    @(posedge clk); @(negedge clk);
    chk("t1_re", {31'b0, mgmt_readEnable}, 32'd1);
    chk("t1_addr", {12'b0, mgmt_address}, 32'h4);
    mgmt_readData = 32'h13;
    @(posedge clk); @(negedge clk);
    chk("t1_ack", {31'b0, jtag_ack}, 32'd1);
    chk("t1_rd", jtag_readData, 32'h13);
    jtag_req = 0;
    @(posedge clk); @(negedge clk);
    chk("t1_last", {31'b0, lastGrant}, 32'd0);
    m_last = 0; m_jrd = 32'h13;

    // WB write
    wb_we = 1; wb_address = 20'h10020; wb_writeData = 32'hDEAD_BEEF; wb_byteSelect = 4'hF;
    do_txn(0, 1, 0, 0);

    // ties alternate
    for (int i = 0; i < 4; i++) begin
      rand_fields();
      jtag_address = 20'(i * 16); wb_address = 20'(i * 16 + 8);
      do_txn(1, 1, 0, 0);
    end

    // stalled JTAG read with WB waiting
    rand_fields(); jtag_we = 0;
    if (m_last == 0) do_txn(0, 1, 0, 0);
    do_txn(1, 1, 5 < TO ? 5 : TO - 1, 1);

    // reset mid-ACCESS
    rand_fields();
    jtag_req = 1; wb_req = 1;
    @(posedge clk); @(negedge clk);
    mgmt_busy = 1;
    @(posedge clk); @(negedge clk);
    chk("pre_rst_strb", {31'b0, mgmt_writeEnable | mgmt_readEnable}, 32'd1);
    #2 rst = 0;
    #1;
    chk("rst_mid_strb", {30'b0, mgmt_writeEnable, mgmt_readEnable}, 32'd0);
    chk("rst_mid_acks", {30'b0, jtag_ack, wb_ack}, 32'd0);
    chk("rst_mid_last", {31'b0, lastGrant}, 32'd1);
    jtag_req = 0; wb_req = 0; mgmt_busy = 0;
    @(negedge clk); rst = 1;
    m_last = 1; m_jrd = 0; m_wrd = 0;
    @(negedge clk);
    rand_fields();
    do_txn(1, 1, 0, 0);
    chk("tie_after_rst", {31'b0, lastGrant}, 32'd0);

`ifdef CORE_MANAGEMENT_TIMEOUT_EN
    rand_fields();
    do_txn(1, 0, 10, 0);
    rand_fields();
    do_txn(1, 0, 1, 0);
`endif

    // random traffic
    for (int i = 0; i < 60; i++) begin
      rand_fields();
      jr = 1'($urandom); wr = 1'($urandom);
      if (!jr && !wr) begin
        @(posedge clk); @(negedge clk);
        chk("idle_hold", {30'b0, mgmt_writeEnable, mgmt_readEnable}, 32'd0);
      end else begin
`ifdef CORE_MANAGEMENT_TIMEOUT_EN
        do_txn(jr, wr, int'($urandom_range(0, 6)), 1'($urandom));
`else
        do_txn(jr, wr, int'($urandom_range(0, 3)), 1'($urandom));
`endif
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
